// File: rtl/vga_capture_pkg.sv
// Shared VGA/Spectrum geometry and the Spectrum bitmap address scramble.
// Also used by the display generator so both ends agree on layout.
package vga_capture_pkg;

   localparam logic [9:0] HA = 10'd640;
   localparam logic [9:0] VA = 10'd480;
   localparam logic [9:0] HB = 10'd64;
   localparam logic [9:0] VB = 10'd48;

   typedef enum logic {
      WR_IDLE,
      WR_PEND
   } wr_state_t;

   function automatic logic [12:0] spec_addr(
      input logic [7:0] y,
      input logic [4:0] xb
   );
      return {y[7:6], y[2:0], y[5:3], xb};
   endfunction

endpackage

// File: rtl/vga_capture_sync_edge.sv
// Registers one input bit and flags its rising/falling edges,
// aligned with the registered copy.
module sync_edge #(
   parameter logic INIT = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic q_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         q   <= INIT;
         q_d <= INIT;
      end else begin
         q   <= d;
         q_d <= q;
      end
   end

   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/vga_capture.sv
// Rebuilds the 256x192 Spectrum bitmap from the 640x480 VGA stream
// and writes it byte by byte through a valid/ready port.
module vga_capture (
   input  logic        clk,
   input  logic        reset,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic        vga_de,
   input  logic [3:0]  vga_g,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [12:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        frame_done,
   output logic        overflow,
   output logic        frame_err
);

   import vga_capture_pkg::*;

   logic de, de_rise, de_fall;
   logic vs_fall, unused_vs_q, unused_vs_rise;
   logic pix, hs_q;

   sync_edge #(.INIT(1'b0)) u_de (
      .clk  (clk),
      .reset(reset),
      .d    (vga_de),
      .q    (de),
      .rise (de_rise),
      .fall (de_fall)
   );

   sync_edge #(.INIT(1'b1)) u_vs (
      .clk  (clk),
      .reset(reset),
      .d    (vga_vs),
      .q    (unused_vs_q),
      .rise (unused_vs_rise),
      .fall (vs_fall)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         pix  <= 1'b0;
         hs_q <= 1'b1;
      end else begin
         pix  <= vga_g[3];
         hs_q <= vga_hs;
      end
   end

   logic [9:0] hc, vc, hpos, dx, dy;
   logic       armed, short_line;

   // hc holds the index of the next pixel; hpos is the current one
   assign hpos = de_rise ? 10'd0 : hc;
   assign dx   = hpos - HB;
   assign dy   = vc - VB;

   always_ff @(posedge clk) begin
      if (!reset) begin
         hc <= '0;
      end else if (de) begin
         hc <= (hpos == 10'h3FF) ? hpos : hpos + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vc <= '0;
      end else if (vs_fall) begin
         vc <= '0;
      end else if (de_fall && vc != 10'h3FF) begin
         vc <= vc + 10'd1;
      end
   end

   logic       in_win, sample, done;
   logic [7:0] x, y, sh, byte_new;

   assign in_win = de && hpos >= HB && hpos < HA - HB
                   && vc >= VB && vc < VA - VB;
   assign x        = dx[8:1];
   assign y        = dy[8:1];
   assign sample   = in_win && !dx[0] && !dy[0];
   assign byte_new = {sh[6:0], pix};
   assign done     = sample && armed && x[2:0] == 3'd7;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sh <= '0;
      end else if (sample) begin
         sh <= byte_new;
      end
   end

   // Nothing is written until a whole frame can start cleanly
   always_ff @(posedge clk) begin
      if (!reset) begin
         armed <= 1'b0;
      end else if (vs_fall) begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         short_line <= 1'b0;
         frame_err  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= vs_fall;
         if (vs_fall) begin
            short_line <= 1'b0;
            frame_err  <= (vc < VA) | short_line;
         end else if (de_fall && hc < HA) begin
            short_line <= 1'b1;
         end
      end
   end

   wr_state_t state, state_nxt;
   logic      load, drop;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= WR_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      drop      = 1'b0;
      unique case (state)
         WR_IDLE: begin
            if (done) begin
               load      = 1'b1;
               state_nxt = WR_PEND;
            end
         end
         WR_PEND: begin
            if (wr_ready) begin
               if (done) begin
                  load = 1'b1;
               end else begin
                  state_nxt = WR_IDLE;
               end
            end else if (done) begin
               drop = 1'b1;
            end
         end
         default: state_nxt = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_addr  <= '0;
         wr_data  <= '0;
         overflow <= 1'b0;
      end else begin
         if (load) begin
            wr_addr <= spec_addr(y, x[7:3]);
            wr_data <= byte_new;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   assign wr_valid = (state == WR_PEND);

   logic unused_bits;
   assign unused_bits = ^{hs_q, vga_g[2:0], dx[9], dy[9],
                          unused_vs_q, unused_vs_rise};

endmodule

// File: doc/vga_capture.md
# vga_capture

Receives the team's 640x480 VGA pixel stream (HS/VS/DE plus 4-bit colour) and rebuilds the 256x192 ZX Spectrum bitmap from it. Each captured byte is written into a Spectrum-layout display memory through a valid/ready write port. It sits at the far end of the video output path and is used for loopback checking of the display generator and for frame grabbing. Geometry is fixed: 2x pixel doubling, 64-pixel horizontal border, 48-line vertical border.

## Interface
- HA, 640, active pixels per line
- VA, 480, active lines per frame
- HB, 64, horizontal border width in input pixels
- VB, 48, vertical border height in input lines
- clk  in  1  pixel clock, same clock as the video source
- reset  in  1  synchronous, active-low reset
- vga_hs  in  1  horizontal sync, active-low
- vga_vs  in  1  vertical sync, active-low
- vga_de  in  1  data enable, active-high
- vga_g  in  4  green channel; a pixel is lit when vga_g[3]=1
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts the write when wr_valid and wr_ready are both high on a clock edge
- wr_addr  out  13  Spectrum bitmap address
- wr_data  out  8  bitmap byte, MSB is the leftmost pixel
- frame_done  out  1  one-cycle pulse when vga_vs asserts
- overflow  out  1  sticky; a completed byte was dropped
- frame_err  out  1  previous frame had fewer than VA active lines or a line shorter than HA

## Operation
- Input stage: vga_hs, vga_vs, vga_de and vga_g[3] are registered once. All logic below uses the registered copies.
- Horizontal counter hc (10 bits):
  - Cleared on a DE rising edge.
  - Increments while DE is high.
  - Saturates at 1023.
- Vertical counter vc (10 bits):
  - Increments on each DE falling edge.
  - Cleared when VS asserts.
  - Saturates at 1023.
- Capture window: HB ≤ hc < HA−HB and VB ≤ vc < VA−VB, with DE high.
- Coordinates: x = (hc−HB)>>1 (8 bits) and y = (vc−VB)>>1 (8 bits).
- Sampling:
  - Only the first line of each pair is sampled ((vc−VB)[0]=0).
  - Only the first pixel of each pair is sampled ((hc−HB)[0]=0).
- Sampled bits are shifted in MSB-first. When x[2:0]=7, the byte is complete and is latched into the output holding register with wr_addr = {y[7:6], y[2:0], y[5:3], x[7:3]}.
- Output FSM:
  - IDLE → PEND when a byte completes.
  - PEND → IDLE when wr_ready is high.
  - A byte that completes while in PEND (with no acceptance that cycle) is dropped and sets overflow.
  - If a byte completes in the same cycle that the pending one is accepted, the new byte is loaded and the FSM stays in PEND.
- Frame check: DE-high width is measured per line.
  - At VS assertion, frame_err is updated: it is set if vc < VA or any line in the frame was shorter than HA.
  - Widths longer than HA and extra lines beyond VA are tolerated.
- overflow clears only on reset.

## Timing
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, overflow=0, frame_err=0, FSM=IDLE, hc=vc=0, shift register=0.
- Latency: wr_valid rises on the 2nd rising edge after the clock in which the byte's last sampled pixel is on the pins.
- wr_addr and wr_data are stable while wr_valid is high.
- frame_done pulses on the 2nd edge after vga_vs first goes low.
- Nominal byte rate is one per 16 clocks. wr_ready may stall for up to 15 clocks without loss.
- Reset asserted mid-line discards the partial byte and any pending write. Capture resumes at the next DE rising edge, but no bytes are written until the first VS assertion after reset.

## Structure
- A shared package holds the geometry constants (HA, VA, HB, VB) and the Spectrum address-scramble function, shared with the display generator.
- One natural sub-module, sync_edge: registers a signal and produces rise/fall pulses. It is instantiated for DE and VS.

## Test plan
- Reset, then a full frame with every active pixel lit and wr_ready=1 → exactly 6144 writes, all wr_data=0xFF, first wr_addr=0x0000, last wr_addr=0x17FF, frame_err=0.
- Spectrum row y=1, pixels x=0..7 carrying the pattern 10100101 (each pixel 2 clocks wide, line pair duplicated), rest blank → write wr_addr=0x0100, wr_data=0xA5.
- Border pixels lit, window blank → all 6144 writes are 0x00.
- wr_ready held low for 20 clocks mid-line → the first byte is held and then written, one byte is dropped, overflow=1 and stays 1 until reset.
- Frame with only 470 DE lines → frame_err=1 after that VS. Next full frame → frame_err=0.
- Reset asserted for 3 clocks mid-line → outputs at reset values, no writes until after the next VS, then correct capture resumes.
